// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported fixed-latency memory between the fetch (I) and data (D) requesters.
// Optional build macro ARB_ROUND_ROBIN_EN: simultaneous I+D requests alternate instead of fixed D priority.
module mem_port_arbiter #(
    parameter int WORD_SIZE   = 16,
    parameter int MEM_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic [WORD_SIZE-1:0] i_rdata,
    output logic                 i_ready,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 d_ready,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 grant_q, grant_d;
    logic                 we_q, we_d;
    logic [WORD_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;
    logic [WORD_SIZE-1:0] i_rdata_q, i_rdata_d;
    logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;
    logic                 pick;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_q, last_grant_d;

    assign pick = (i_req && d_req) ? !last_grant_q : d_req;

    // Remember the most recent grant so conflicts alternate between ports.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) last_grant_q <= 1'b0;
        else          last_grant_q <= last_grant_d;
    end

    // Any issued grant, conflicting or not, becomes the new last grant.
    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == IDLE && (i_req || d_req)) last_grant_d = pick;
    end
`else
    // D wins any conflict: the MEM stage is older, so stalling it behind a fetch could deadlock.
    assign pick = d_req;
`endif

    // State register and latched access; grant 1 means D, 0 means I.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            grant_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    // Grant in IDLE, hold the strobe for MEM_LATENCY cycles, then one response cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    grant_d = pick;
                    we_d    = pick && d_we;
                    addr_d  = pick ? d_addr : i_addr;
                    wdata_d = pick ? d_wdata : '0;
                    cnt_d   = 4'(MEM_LATENCY - 1);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    if (!we_q && grant_q)  d_rdata_d = mem_rdata;
                    if (!we_q && !grant_q) i_rdata_d = mem_rdata;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mem_read  = (state_q == ACCESS) && !we_q;
    assign mem_write = (state_q == ACCESS) && we_q;
    assign mem_addr  = (state_q == ACCESS) ? addr_q : '0;
    assign mem_wdata = (state_q == ACCESS) ? wdata_q : '0;
    assign i_ready   = (state_q == RESP) && !grant_q;
    assign d_ready   = (state_q == RESP) && grant_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign busy      = state_q != IDLE;
endmodule
